// File: rtl/dsi_pkg.sv
// Shared definitions for the MIPI DSI lane controllers: clock-lane states,
// default D-PHY timing counts and LP line-level encodings.
package dsi_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LPX,
        ST_PREP,
        ST_ZERO,
        ST_PRE,
        ST_HS,
        ST_POST,
        ST_TRAIL,
        ST_EXIT
    } clk_lane_state_e;

    localparam int unsigned T_LPX_DEF         = 2;
    localparam int unsigned T_CLK_PREPARE_DEF = 2;
    localparam int unsigned T_CLK_ZERO_DEF    = 8;
    localparam int unsigned T_CLK_PRE_DEF     = 4;
    localparam int unsigned T_CLK_POST_DEF    = 8;
    localparam int unsigned T_CLK_TRAIL_DEF   = 3;
    localparam int unsigned T_HS_EXIT_DEF     = 4;
    localparam int unsigned CNT_W_DEF         = 8;

    // LP levels packed as {lp_p, lp_n}.
    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;

    typedef struct packed {
        logic [1:0] lp;
        logic       hs_oe;
        logic       hs_toggle;
        logic       hs_ready;
        logic       busy;
    } clk_lane_out_t;

    function automatic clk_lane_out_t decode_outputs(clk_lane_state_e st);
        clk_lane_out_t o;
        o.lp        = LP00;
        o.hs_oe     = 1'b0;
        o.hs_toggle = 1'b0;
        o.hs_ready  = 1'b0;
        o.busy      = (st != ST_IDLE);
        case (st)
            ST_IDLE, ST_EXIT: o.lp = LP11;
            ST_LPX:           o.lp = LP01;
            ST_ZERO, ST_TRAIL: o.hs_oe = 1'b1;
            ST_PRE, ST_POST: begin
                o.hs_oe     = 1'b1;
                o.hs_toggle = 1'b1;
            end
            ST_HS: begin
                o.hs_oe     = 1'b1;
                o.hs_toggle = 1'b1;
                o.hs_ready  = 1'b1;
            end
            default: o.lp = LP00;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/dsi_clk_lane_ctrl_if.sv
// Clock-lane control bundle: request/ready handshake plus the PHY-facing
// LP levels and HS driver controls.
interface dsi_clk_lane_ctrl_if;

    logic hs_req;
    logic hs_ready;
    logic busy;
    logic clk_hs_oe;
    logic clk_hs_toggle;
    logic lp_p;
    logic lp_n;

    modport master (
        output hs_req,
        input  hs_ready, busy, clk_hs_oe, clk_hs_toggle, lp_p, lp_n
    );

    modport slave (
        input  hs_req,
        output hs_ready, busy, clk_hs_oe, clk_hs_toggle, lp_p, lp_n
    );

endinterface

// File: rtl/lane_timer.sv
// Load-and-count-down interval timer; done is high whenever the count is zero
// and the count rests there until the next load.
module lane_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: state registers take <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/dsi_clk_lane_ctrl.sv
// D-PHY clock-lane sequencer: LP-11 stop state <-> continuous HS clock, with
// every timed phase lasting exactly its programmed cycle count.
module dsi_clk_lane_ctrl
    import dsi_pkg::*;
#(
    parameter int unsigned T_LPX         = T_LPX_DEF,
    parameter int unsigned T_CLK_PREPARE = T_CLK_PREPARE_DEF,
    parameter int unsigned T_CLK_ZERO    = T_CLK_ZERO_DEF,
    parameter int unsigned T_CLK_PRE     = T_CLK_PRE_DEF,
    parameter int unsigned T_CLK_POST    = T_CLK_POST_DEF,
    parameter int unsigned T_CLK_TRAIL   = T_CLK_TRAIL_DEF,
    parameter int unsigned T_HS_EXIT     = T_HS_EXIT_DEF,
    parameter int unsigned CNT_W         = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    dsi_clk_lane_ctrl_if.slave  lane
);

    localparam logic [CNT_W-1:0] LD_LPX   = CNT_W'(T_LPX - 1);
    localparam logic [CNT_W-1:0] LD_PREP  = CNT_W'(T_CLK_PREPARE - 1);
    localparam logic [CNT_W-1:0] LD_ZERO  = CNT_W'(T_CLK_ZERO - 1);
    localparam logic [CNT_W-1:0] LD_PRE   = CNT_W'(T_CLK_PRE - 1);
    localparam logic [CNT_W-1:0] LD_POST  = CNT_W'(T_CLK_POST - 1);
    localparam logic [CNT_W-1:0] LD_TRAIL = CNT_W'(T_CLK_TRAIL - 1);
    localparam logic [CNT_W-1:0] LD_EXIT  = CNT_W'(T_HS_EXIT - 1);

    clk_lane_state_e  state_q;
    clk_lane_state_e  state_d;
    clk_lane_out_t    out_q;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;

    lane_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (1'b1),
        .done_o     (tmr_done)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE: if (lane.hs_req) begin
                state_d = ST_LPX;   tmr_load = 1'b1; tmr_val = LD_LPX;
            end
            ST_LPX: if (tmr_done) begin
                state_d = ST_PREP;  tmr_load = 1'b1; tmr_val = LD_PREP;
            end
            ST_PREP: if (tmr_done) begin
                state_d = ST_ZERO;  tmr_load = 1'b1; tmr_val = LD_ZERO;
            end
            ST_ZERO: if (tmr_done) begin
                state_d = ST_PRE;   tmr_load = 1'b1; tmr_val = LD_PRE;
            end
            // A request withdrawn during entry skips HS so hs_ready never pulses.
            ST_PRE: if (tmr_done) begin
                if (lane.hs_req) begin
                    state_d = ST_HS;
                end else begin
                    state_d = ST_POST; tmr_load = 1'b1; tmr_val = LD_POST;
                end
            end
            ST_HS: if (!lane.hs_req) begin
                state_d = ST_POST;  tmr_load = 1'b1; tmr_val = LD_POST;
            end
            ST_POST: if (tmr_done) begin
                state_d = ST_TRAIL; tmr_load = 1'b1; tmr_val = LD_TRAIL;
            end
            ST_TRAIL: if (tmr_done) begin
                state_d = ST_EXIT;  tmr_load = 1'b1; tmr_val = LD_EXIT;
            end
            ST_EXIT: if (tmr_done) begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it,
    // so they change on the same edge as the state and never see hs_req directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            out_q   <= decode_outputs(ST_IDLE);
        end else begin
            state_q <= state_d;
            out_q   <= decode_outputs(state_d);
        end
    end

    assign lane.lp_p          = out_q.lp[1];
    assign lane.lp_n          = out_q.lp[0];
    assign lane.clk_hs_oe     = out_q.hs_oe;
    assign lane.clk_hs_toggle = out_q.hs_toggle;
    assign lane.hs_ready      = out_q.hs_ready;
    assign lane.busy          = out_q.busy;

endmodule
